// File: rtl/ct_f_spsram_512x22_ctrl.sv
// rtl/ct_f_spsram_512x22_ctrl.sv - single-port SRAM controller with zero-fill sweep and 3-deep read response FIFO
module ct_f_spsram_512x22_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 22,
    parameter int WRAP_SIZE  = 11,
    parameter int INIT_EN    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [1:0]            req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    typedef enum logic [1:0] {
        RST_IDLE = 2'd0,
        INIT     = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  rd_inflight;
    logic [1:0]            fifo_cnt;
    logic [1:0]            wr_ptr;
    logic [1:0]            rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_mem [3];
    logic                  accept;
    logic                  push;
    logic                  pop;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Reserve a FIFO slot for a read still waiting on Q so the FIFO cannot overflow
    assign req_rdy = (state == RUN) && (({1'b0, fifo_cnt} + {2'b00, rd_inflight}) < 3'd3);
    assign accept  = req_vld && req_rdy;
    assign push    = rd_inflight;
    assign rsp_vld = (fifo_cnt != 2'd0);
    assign pop     = rsp_vld && rsp_rdy;

    always_comb begin
        rsp_rdata = fifo_mem[0];
        for (int i = 1; i < 3; i++) begin
            if (rd_ptr == i[1:0]) begin
                rsp_rdata = fifo_mem[i];
            end
        end
    end

    always_comb begin
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        A    = a_q;
        D    = d_q;
        if (state == INIT) begin
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
            A    = init_cnt;
            D    = '0;
        end else if (accept) begin
            CEN  = 1'b0;
            GWEN = ~req_wr;
            A    = req_addr;
            D    = req_wdata;
            if (req_wr) begin
                WEN = {{(DATA_WIDTH-WRAP_SIZE){~req_wmask[1]}}, {WRAP_SIZE{~req_wmask[0]}}};
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= RST_IDLE;
            init_cnt  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                RST_IDLE: begin
                    if (INIT_EN != 0) begin
                        state <= INIT;
                    end else begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                end
                default: begin
                    state     <= RST_IDLE;
                    init_done <= 1'b0;
                end
            endcase
        end
    end

    // A and D remember the last driven value so idle cycles do not toggle the SRAM pins
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            a_q         <= '0;
            d_q         <= '0;
            rd_inflight <= 1'b0;
            fifo_cnt    <= 2'd0;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (state == INIT) begin
                a_q <= init_cnt;
                d_q <= '0;
            end else if (accept) begin
                a_q <= req_addr;
                d_q <= req_wdata;
            end
            rd_inflight <= accept && !req_wr;
            if (push) begin
                for (int i = 0; i < 3; i++) begin
                    if (wr_ptr == i[1:0]) begin
                        fifo_mem[i] <= Q;
                    end
                end
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_ct_f_spsram_512x22_ctrl.sv
// tb/tb_ct_f_spsram_512x22_ctrl.sv - self-checking bench for ct_f_spsram_512x22_ctrl
module tb_ct_f_spsram_512x22_ctrl;

    localparam int AW = 9;
    localparam int DW = 22;
    localparam int HW = 11;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [1:0]    req_wmask = 2'b00;
    logic          rsp_vld;
    logic          rsp_rdy;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;
    logic [AW-1:0] A;
    logic          CEN;
    logic          GWEN;
    logic [DW-1:0] WEN;
    logic [DW-1:0] D;
    logic [DW-1:0] Q = '0;

    logic man_rdy = 1'b1;
    logic rand_mode = 1'b0;
    logic rand_bit = 1'b0;
    assign rsp_rdy = rand_mode ? rand_bit : man_rdy;

    int n_chk = 0;
    int n_fail = 0;

    logic [DW-1:0] sram    [1 << AW];
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] exp_q   [$];
    logic [DW-1:0] cap_wen;

    ct_f_spsram_512x22_ctrl dut (
        .CLK       (CLK),
        .RST       (RST),
        .req_vld   (req_vld),
        .req_rdy   (req_rdy),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done),
        .A         (A),
        .CEN       (CEN),
        .GWEN      (GWEN),
        .WEN       (WEN),
        .D         (D),
        .Q         (Q)
    );

    initial forever #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = DW'($urandom);
        end
    end

    always @(posedge CLK) begin
        if (!CEN) begin
            if (!GWEN) begin
                sram[A] <= (sram[A] & WEN) | (D & ~WEN);
            end else begin
                Q <= sram[A];
            end
        end
    end

    initial forever begin
        @(posedge CLK);
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge CLK) begin
        if (!RST && rsp_vld && rsp_rdy) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_rdata), 64'hDEAD_BEEF_0000_0000);
            end else begin
                chk("rsp_order", 64'(rsp_rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [1:0] m, output int waited);
        logic [DW-1:0] ewen;
        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_wmask = m;
        waited    = 0;
        @(negedge CLK);
        while (!req_rdy && waited < 50) begin
            waited++;
            @(negedge CLK);
        end
        if (!req_rdy) begin
            chk("rdy_timeout", 64'(req_rdy), 64'd1);
            req_vld = 1'b0;
            return;
        end
        for (int b = 0; b < DW; b++) begin
            ewen[b] = !(wr && m[b / HW]);
        end
        cap_wen = WEN;
        chk("acc_cen", 64'(CEN), 64'd0);
        chk("acc_gwen", 64'(GWEN), 64'(!wr));
        chk("acc_wen", 64'(WEN), 64'(ewen));
        chk("acc_addr", 64'(A), 64'(addr));
        chk("acc_d", 64'(D), 64'(wd));
        if (wr) begin
            for (int b = 0; b < DW; b++) begin
                if (m[b / HW]) ref_mem[addr][b] = wd[b];
            end
        end else begin
            exp_q.push_back(ref_mem[addr]);
        end
        @(posedge CLK);
        #1;
        req_vld = 1'b0;
    endtask

    task automatic init_sweep();
        int bad;
        bad = 0;
        @(negedge CLK);
        chk("idle_cen", 64'(CEN), 64'd1);
        chk("idle_init_done", 64'(init_done), 64'd0);
        for (int i = 0; i < (1 << AW); i++) begin
            @(negedge CLK);
            if (CEN !== 1'b0 || GWEN !== 1'b0 || WEN !== '0 || D !== '0 ||
                A !== AW'(i) || req_rdy !== 1'b0 || init_done !== 1'b0) begin
                bad++;
            end
        end
        chk("init_sweep_bad_cycles", 64'(bad), 64'd0);
        @(negedge CLK);
        chk("init_done_rise", 64'(init_done), 64'd1);
        chk("init_end_cen", 64'(CEN), 64'd1);
        chk("run_rdy", 64'(req_rdy), 64'd1);
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = '0;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input string name, input int exp_cycles);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 40) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        if (exp_cycles >= 0) chk({name, "_cycles"}, 64'(cyc), 64'(exp_cycles));
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [1:0]    mask;
        logic [DW-1:0] exp_wen;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int waited;
        int stalls;

        vecs[0]  = '{1'b1, 9'd7,     22'h02AAAA, 2'b11, 22'h000000, 22'h000000};
        vecs[1]  = '{1'b0, 9'd7,     22'h000000, 2'b00, 22'h3FFFFF, 22'h02AAAA};
        vecs[2]  = '{1'b1, 9'd9,     22'h3FFFFF, 2'b01, 22'h3FF800, 22'h000000};
        vecs[3]  = '{1'b0, 9'd9,     22'h000000, 2'b00, 22'h3FFFFF, 22'h0007FF};
        vecs[4]  = '{1'b1, 9'd9,     22'h155555, 2'b10, 22'h0007FF, 22'h000000};
        vecs[5]  = '{1'b0, 9'd9,     22'h000000, 2'b00, 22'h3FFFFF, 22'h1557FF};
        vecs[6]  = '{1'b1, 9'h1FF,   22'h3FFFFF, 2'b00, 22'h3FFFFF, 22'h000000};
        vecs[7]  = '{1'b0, 9'h1FF,   22'h000000, 2'b00, 22'h3FFFFF, 22'h000000};
        vecs[8]  = '{1'b0, 9'h1A5,   22'h000000, 2'b00, 22'h3FFFFF, 22'h000000};
        vecs[9]  = '{1'b1, 9'd0,     22'h123456, 2'b11, 22'h000000, 22'h000000};
        vecs[10] = '{1'b0, 9'd0,     22'h000000, 2'b00, 22'h3FFFFF, 22'h123456};

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_cen", 64'(CEN), 64'd1);
        chk("rst_gwen", 64'(GWEN), 64'd1);
        chk("rst_wen", 64'(WEN), 64'h3FFFFF);
        chk("rst_req_rdy", 64'(req_rdy), 64'd0);
        chk("rst_init_done", 64'(init_done), 64'd0);
        chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_a", 64'(A), 64'd0);
        chk("rst_d", 64'(D), 64'd0);
        chk("rst_rdata", 64'(rsp_rdata), 64'd0);
        RST = 1'b0;
        init_sweep();

        man_rdy = 1'b1;
        foreach (vecs[k]) begin
            issue(vecs[k].wr, vecs[k].addr, vecs[k].wdata, vecs[k].mask, waited);
            chk("vec_wait", 64'(waited), 64'd0);
            chk("vec_wen", 64'(cap_wen), 64'(vecs[k].exp_wen));
            @(negedge CLK);
            chk("hold_cen", 64'(CEN), 64'd1);
            chk("hold_gwen", 64'(GWEN), 64'd1);
            chk("hold_wen", 64'(WEN), 64'h3FFFFF);
            chk("hold_a", 64'(A), 64'(vecs[k].addr));
            chk("hold_d", 64'(D), 64'(vecs[k].wdata));
            chk("rsp_vld_n1", 64'(rsp_vld), 64'd0);
            @(posedge CLK);
            #1;
            if (!vecs[k].wr) begin
                @(negedge CLK);
                chk("rsp_vld_n2", 64'(rsp_vld), 64'd1);
                chk("vec_rdata", 64'(rsp_rdata), 64'(vecs[k].exp_rdata));
                @(posedge CLK);
                #1;
            end else begin
                @(negedge CLK);
                chk("write_no_rsp", 64'(rsp_vld), 64'd0);
                @(posedge CLK);
                #1;
            end
        end

        // full FIFO with responses stalled, then drain and let the fourth read in
        man_rdy = 1'b0;
        issue(1'b0, 9'd7, '0, 2'b00, waited);
        issue(1'b0, 9'd9, '0, 2'b00, waited);
        issue(1'b0, 9'd0, '0, 2'b00, waited);
        chk("third_wait", 64'(waited), 64'd0);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 9'h1FF;
        @(negedge CLK);
        chk("rdy_drop", 64'(req_rdy), 64'd0);
        chk("stall_rsp_vld", 64'(rsp_vld), 64'd1);
        chk("stall_rdata", 64'(rsp_rdata), 64'h2AAAA);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("rdy_still_low", 64'(req_rdy), 64'd0);
        chk("stall_rdata_hold", 64'(rsp_rdata), 64'h2AAAA);
        @(posedge CLK);
        #1;
        man_rdy = 1'b1;
        issue(1'b0, 9'h1FF, '0, 2'b00, waited);
        chk("fourth_wait", 64'(waited), 64'd1);
        drain("stall_drain", -1);

        stalls = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, 9'(i * 3), '0, 2'b00, waited);
            stalls += waited;
        end
        chk("b2b_stalls", 64'(stalls), 64'd0);
        drain("b2b_latency", 2);

        // a write right behind a read must not disturb that read's data
        issue(1'b0, 9'd7, '0, 2'b00, waited);
        issue(1'b1, 9'd7, 22'h3C3C3C, 2'b11, waited);
        issue(1'b0, 9'd7, '0, 2'b00, waited);
        drain("rd_wr_drain", -1);

        rand_mode = 1'b1;
        for (int i = 0; i < 250; i++) begin
            issue(1'($urandom_range(0, 1)), 9'h100 + 9'($urandom_range(0, 15)),
                  DW'($urandom), 2'($urandom_range(0, 3)), waited);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end
        rand_mode = 1'b0;
        man_rdy = 1'b1;
        drain("rand_drain", -1);

        man_rdy = 1'b0;
        issue(1'b0, 9'd7, '0, 2'b00, waited);
        issue(1'b0, 9'd9, '0, 2'b00, waited);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        chk("pre_rst_rsp_vld", 64'(rsp_vld), 64'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("async_rst_cen", 64'(CEN), 64'd1);
        chk("async_rst_rdy", 64'(req_rdy), 64'd0);
        chk("async_rst_init_done", 64'(init_done), 64'd0);
        chk("async_rst_a", 64'(A), 64'd0);
        chk("async_rst_d", 64'(D), 64'd0);
        chk("async_rst_rdata", 64'(rsp_rdata), 64'd0);
        exp_q.delete();
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        init_sweep();
        man_rdy = 1'b1;
        issue(1'b0, 9'd7, '0, 2'b00, waited);
        issue(1'b0, 9'h105, '0, 2'b00, waited);
        drain("post_rst_drain", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
